day1_instruction_sequencer: RTL and testbench

//  Front-end controller for the day-1 dial solver. Parses an ASCII byte stream of

---
 rtl/day1_instruction_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_day1_instruction_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day1_instruction_sequencer.sv
// Day-1 dial solver front end: parses "L68\n"-style ASCII lines into direction/count
// instructions, feeds the solver, then drains it and latches hits/passes.
// Optional DAY1_PARSE_ERR_EN adds a sticky parse_error output for unexpected bytes.
module day1_instruction_sequencer #(
  parameter int COUNT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    solver_reset,
  output logic                    direction,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic                    instruction_valid,
  input  logic                    instruction_ready,
  input  logic                    solver_busy,
  input  logic [RESULT_WIDTH-1:0] solver_hits,
  input  logic [RESULT_WIDTH-1:0] solver_passes,
  output logic [RESULT_WIDTH-1:0] lines_issued,
  output logic                    done,
`ifdef DAY1_PARSE_ERR_EN
  output logic                    parse_error,
`endif
  output logic [RESULT_WIDTH-1:0] final_hits,
  output logic [RESULT_WIDTH-1:0] final_passes
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DIR   = 3'd2,
    NUM   = 3'd3,
    ISSUE = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ACC_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_HT = 8'h09;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  acc_q, acc_d;
  logic                    dir_q, dir_d;
  logic                    last_q, last_d;
  logic [RESULT_WIDTH-1:0] lines_q, lines_d;
  logic                    done_q, done_d;
  logic [RESULT_WIDTH-1:0] fhits_q, fhits_d;
  logic [RESULT_WIDTH-1:0] fpasses_q, fpasses_d;
  logic                    in_ready_q, in_ready_d;
  logic                    sreset_q, sreset_d;
  logic                    ivalid_q, ivalid_d;
`ifdef DAY1_PARSE_ERR_EN
  logic                    perr_q, perr_d;
`endif

  logic                    byte_fire;
  logic                    is_digit, is_dir, is_eol, is_ws;
  logic [COUNT_WIDTH+3:0]  acc_ext, acc_wide;
  logic [COUNT_WIDTH-1:0]  acc_sat;

  assign byte_fire = in_valid & in_ready_q;
  assign is_digit  = (in_data >= CH_0) && (in_data <= CH_9);
  assign is_dir    = (in_data == CH_L) || (in_data == CH_R);
  assign is_eol    = (in_data == CH_LF) || (in_data == CH_CR);
  assign is_ws     = is_eol || (in_data == CH_SP) || (in_data == CH_HT);

  // acc*10 + digit computed 4 bits wider so overflow is visible before clamping
  assign acc_ext  = {4'b0000, acc_q};
  assign acc_wide = (acc_ext << 3) + (acc_ext << 1) + {{COUNT_WIDTH{1'b0}}, in_data[3:0]};
  assign acc_sat  = (acc_wide > {4'b0000, ACC_MAX}) ? ACC_MAX : acc_wide[COUNT_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dir_d     = dir_q;
    last_d    = last_q;
    lines_d   = lines_q;
    done_d    = done_q;
    fhits_d   = fhits_q;
    fpasses_d = fpasses_q;
`ifdef DAY1_PARSE_ERR_EN
    perr_d    = perr_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CLEAR;
          acc_d     = '0;
          dir_d     = 1'b0;
          last_d    = 1'b0;
          lines_d   = '0;
          done_d    = 1'b0;
          fhits_d   = '0;
          fpasses_d = '0;
`ifdef DAY1_PARSE_ERR_EN
          perr_d    = 1'b0;
`endif
        end
      end

      CLEAR: state_d = DIR;

      DIR: begin
        if (byte_fire) begin
          if (is_dir) begin
            dir_d = (in_data == CH_R);
            acc_d = '0;
            if (in_last) begin
              last_d  = 1'b1;
              state_d = ISSUE;
            end else begin
              state_d = NUM;
            end
          end else begin
`ifdef DAY1_PARSE_ERR_EN
            if (!is_ws) perr_d = 1'b1;
`endif
            if (in_last) begin
              last_d  = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end

      NUM: begin
        if (byte_fire) begin
          if (is_digit) begin
            acc_d = acc_sat;
          end
`ifdef DAY1_PARSE_ERR_EN
          else if (!is_ws) begin
            perr_d = 1'b1;
          end
`endif
          if (in_last) last_d = 1'b1;
          if (in_last || is_eol) state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (ivalid_q && instruction_ready) begin
          lines_d = lines_q + RESULT_WIDTH'(1);
          state_d = last_q ? DRAIN : DIR;
        end
      end

      // Solver counters already reflect the last accepted instruction here
      DRAIN: begin
        if (!solver_busy && instruction_ready) begin
          fhits_d   = solver_hits;
          fpasses_d = solver_passes;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready_d = (state_d == DIR) || (state_d == NUM);
  assign sreset_d   = (state_d == CLEAR);
  assign ivalid_d   = (state_d == ISSUE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      dir_q      <= 1'b0;
      last_q     <= 1'b0;
      lines_q    <= '0;
      done_q     <= 1'b0;
      fhits_q    <= '0;
      fpasses_q  <= '0;
      in_ready_q <= 1'b0;
      sreset_q   <= 1'b0;
      ivalid_q   <= 1'b0;
`ifdef DAY1_PARSE_ERR_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dir_q      <= dir_d;
      last_q     <= last_d;
      lines_q    <= lines_d;
      done_q     <= done_d;
      fhits_q    <= fhits_d;
      fpasses_q  <= fpasses_d;
      in_ready_q <= in_ready_d;
      sreset_q   <= sreset_d;
      ivalid_q   <= ivalid_d;
`ifdef DAY1_PARSE_ERR_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign in_ready          = in_ready_q;
  assign solver_reset      = sreset_q;
  assign direction         = dir_q;
  assign count             = acc_q;
  assign instruction_valid = ivalid_q;
  assign lines_issued      = lines_q;
  assign done              = done_q;
  assign final_hits        = fhits_q;
  assign final_passes      = fpasses_q;
`ifdef DAY1_PARSE_ERR_EN
  assign parse_error       = perr_q;
`endif

endmodule

// File: tb/tb_day1_instruction_sequencer.sv
// Bench for day1_instruction_sequencer: emulated dial solver, table vectors,
// hand-written corner sequences and randomized programs against a click-level model.
module tb_day1_instruction_sequencer;
  localparam int CW = 16;
  localparam int RW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          solver_reset;
  logic          direction;
  logic [CW-1:0] count;
  logic          instruction_valid;
  logic          instruction_ready;
  logic          solver_busy;
  logic [RW-1:0] solver_hits;
  logic [RW-1:0] solver_passes;
  logic [RW-1:0] lines_issued;
  logic          done;
  logic [RW-1:0] final_hits;
  logic [RW-1:0] final_passes;
`ifdef DAY1_PARSE_ERR_EN
  logic          parse_error;
`endif

  int errors = 0;
  int checks = 0;

  day1_instruction_sequencer #(.COUNT_WIDTH(CW), .RESULT_WIDTH(RW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .solver_reset(solver_reset), .direction(direction), .count(count),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .solver_busy(solver_busy), .solver_hits(solver_hits), .solver_passes(solver_passes),
    .lines_issued(lines_issued), .done(done),
`ifdef DAY1_PARSE_ERR_EN
    .parse_error(parse_error),
`endif
    .final_hits(final_hits), .final_passes(final_passes)
  );

  always #5 clock = ~clock;

  // Emulated solver: dial 0..99 starting at 50, counters updated on handshake
  int sol_pos = 50;
  int sol_hits = 0;
  int sol_passes = 0;
  int busy_cnt = 0;
  int max_lat = 2;
  bit stall = 1'b0;
  int reset_pulses = 0;
  bit log_dir[$];
  int log_cnt[$];

  assign instruction_ready = (busy_cnt == 0) && !stall;
  assign solver_busy       = (busy_cnt != 0);
  assign solver_hits       = sol_hits;
  assign solver_passes     = sol_passes;

  always @(posedge clock) begin
    int p, c, np, pc;
    if (solver_reset) begin
      sol_pos <= 50;
      sol_hits <= 0;
      sol_passes <= 0;
      busy_cnt <= 0;
      reset_pulses++;
    end else if (instruction_valid && instruction_ready) begin
      p = sol_pos;
      c = int'(count);
      if (direction) begin
        pc = (p + c) / 100;
        np = (p + c) % 100;
      end else begin
        if (p == 0) pc = c / 100;
        else if (c >= p) pc = (c - p) / 100 + 1;
        else pc = 0;
        np = (p - (c % 100) + 100) % 100;
      end
      sol_pos <= np;
      sol_hits <= sol_hits + ((np == 0) ? 1 : 0);
      sol_passes <= sol_passes + pc;
      busy_cnt <= $urandom_range(0, max_lat);
      log_dir.push_back(direction);
      log_cnt.push_back(c);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Reference: turn the dial one click at a time
  function automatic void ref_dial(input bit dirs[$], input int cnts[$], output int h, output int p);
    int pos;
    pos = 50; h = 0; p = 0;
    for (int i = 0; i < dirs.size(); i++) begin
      for (int k = 0; k < cnts[i]; k++) begin
        pos = dirs[i] ? (pos + 1) % 100 : (pos + 99) % 100;
        if (pos == 0) p++;
      end
      if (pos == 0) h++;
    end
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit last);
    int t;
    in_data = b; in_valid = 1'b1; in_last = last; t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      checkOutput("byte_accept_timeout", 0, 1);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic send_text(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      applyStimulus(s[i], i == s.len() - 1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic run_text(input string s, input bit gaps, output int pulses);
    int rp0;
    log_dir.delete();
    log_cnt.delete();
    rp0 = reset_pulses;
    pulse_start();
    send_text(s, gaps);
    wait_done();
    pulses = reset_pulses - rp0;
  endtask

  typedef struct {
    string text;
    int    n_issue;
    bit    dir0;
    int    cnt0;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string t, input int n, input bit d, input int c);
    vec_t v;
    v.text = t; v.n_issue = n; v.dir0 = d; v.cnt0 = c;
    vecs.push_back(v);
  endfunction

  localparam string SAMPLE = "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n";

  initial begin
    int pulses, eh, ep, n, v, cap;
    bit qd[$];
    int qc[$];
    string s;

    add_vec("R70000\n", 1, 1'b1, 65535);
    add_vec("\015\nL0\n", 1, 1'b0, 0);
    add_vec("L", 1, 1'b0, 0);
    add_vec("R5", 1, 1'b1, 5);
    add_vec("  \n", 0, 1'b0, 0);
    add_vec("R65535\n", 1, 1'b1, 65535);
    add_vec("R65536\n", 1, 1'b1, 65535);
    add_vec(" L12 3\015\n", 1, 1'b0, 123);
    add_vec("R250\n", 1, 1'b1, 250);

    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_ivalid", instruction_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_solver_reset", solver_reset, 0);
    checkOutput("rst_lines", lines_issued, 0);
    checkOutput("rst_final_hits", final_hits, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_text(SAMPLE, 1'b0, pulses);
    checkOutput("sample_done", done, 1);
    checkOutput("sample_lines", lines_issued, 10);
    checkOutput("sample_hits", final_hits, 3);
    checkOutput("sample_passes", final_passes, 6);
    checkOutput("sample_reset_pulses", pulses, 1);
    checkOutput("sample_in_ready_done", in_ready, 0);
`ifdef DAY1_PARSE_ERR_EN
    checkOutput("sample_parse_error", parse_error, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_text(vecs[i].text, 1'b1, pulses);
      qd.delete(); qc.delete();
      if (vecs[i].n_issue == 1) begin
        qd.push_back(vecs[i].dir0);
        qc.push_back(vecs[i].cnt0);
      end
      ref_dial(qd, qc, eh, ep);
      checkOutput($sformatf("vec%0d_lines", i), lines_issued, vecs[i].n_issue);
      checkOutput($sformatf("vec%0d_log_size", i), log_cnt.size(), vecs[i].n_issue);
      if (vecs[i].n_issue > 0 && log_cnt.size() > 0) begin
        checkOutput($sformatf("vec%0d_dir", i), log_dir[0], vecs[i].dir0);
        checkOutput($sformatf("vec%0d_count", i), log_cnt[0], vecs[i].cnt0);
      end
      checkOutput($sformatf("vec%0d_hits", i), final_hits, eh);
      checkOutput($sformatf("vec%0d_passes", i), final_passes, ep);
      checkOutput($sformatf("vec%0d_reset_pulses", i), pulses, 1);
    end

    // Backpressure: solver refuses for 5 cycles while the instruction is offered
    log_dir.delete(); log_cnt.delete();
    n = reset_pulses;
    stall = 1'b1;
    pulse_start();
    send_text("R7\n", 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_ivalid", i), instruction_valid, 1);
      checkOutput($sformatf("stall%0d_dir", i), direction, 1);
      checkOutput($sformatf("stall%0d_count", i), count, 7);
      checkOutput($sformatf("stall%0d_in_ready", i), in_ready, 0);
      start = (i == 2);
      @(negedge clock);
    end
    start = 1'b0;
    checkOutput("stall_lines_before", lines_issued, 0);
    stall = 1'b0;
    @(negedge clock);
    checkOutput("stall_lines_after", lines_issued, 1);
    checkOutput("stall_log_size", log_cnt.size(), 1);
    wait_done();
    checkOutput("stall_start_ignored", reset_pulses - n, 1);
    checkOutput("stall_hits", final_hits, 0);
    checkOutput("stall_passes", final_passes, 0);

    // Reset in the middle of a number
    pulse_start();
    applyStimulus(8'h4C, 1'b0);
    applyStimulus(8'h36, 1'b0);
    checkOutput("pre_reset_in_ready", in_ready, 1);
    checkOutput("pre_reset_count", count, 6);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_lines", lines_issued, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ivalid", instruction_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_text(SAMPLE, 1'b1, pulses);
    checkOutput("rerun_lines", lines_issued, 10);
    checkOutput("rerun_hits", final_hits, 3);
    checkOutput("rerun_passes", final_passes, 6);

`ifdef DAY1_PARSE_ERR_EN
    run_text("LX5\n", 1'b0, pulses);
    checkOutput("perr_set", parse_error, 1);
    checkOutput("perr_log_size", log_cnt.size(), 1);
    if (log_cnt.size() > 0) checkOutput("perr_count", log_cnt[0], 5);
    pulse_start();
    checkOutput("perr_cleared", parse_error, 0);
    send_text("\n", 1'b0);
    wait_done();
    checkOutput("perr_empty_lines", lines_issued, 0);
`endif

    // Randomized programs against the click-level model
    for (int r = 0; r < 6; r++) begin
      max_lat = $urandom_range(0, 4);
      qd.delete(); qc.delete();
      s = "";
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) s = {s, " "};
        if ($urandom_range(0, 1) == 1) begin
          s = {s, "R"}; qd.push_back(1'b1);
        end else begin
          s = {s, "L"}; qd.push_back(1'b0);
        end
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(60000, 99999) : $urandom_range(0, 350);
        cap = (v > 65535) ? 65535 : v;
        qc.push_back(cap);
        s = {s, $sformatf("%0d", v)};
        s = ($urandom_range(0, 2) == 0) ? {s, "\015\n"} : {s, "\n"};
      end
      run_text(s, 1'b1, pulses);
      ref_dial(qd, qc, eh, ep);
      checkOutput($sformatf("rnd%0d_lines", r), lines_issued, n);
      checkOutput($sformatf("rnd%0d_log_size", r), log_cnt.size(), n);
      for (int k = 0; k < n && k < log_cnt.size(); k++) begin
        checkOutput($sformatf("rnd%0d_dir%0d", r, k), log_dir[k], qd[k]);
        checkOutput($sformatf("rnd%0d_cnt%0d", r, k), log_cnt[k], qc[k]);
      end
      checkOutput($sformatf("rnd%0d_hits", r), final_hits, eh);
      checkOutput($sformatf("rnd%0d_passes", r), final_passes, ep);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
